// File: rtl/vga_timing_pkg.sv
// Shared 1280x1024 timing constants and pattern-sequencer types used by the
// frame controller and the colour generators.
package vga_timing_pkg;

  localparam int H_VISIBLE = 1280;
  localparam int H_FRONT   = 48;
  localparam int H_SYNC    = 112;
  localparam int H_BACK    = 248;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

  localparam int V_VISIBLE = 1024;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 3;
  localparam int V_BACK    = 38;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int CNT_W     = 11;

  typedef logic [2:0] pattern_idx_t;

  typedef enum logic {
    SEQ_IDLE    = 1'b0,
    SEQ_PENDING = 1'b1
  } seq_state_t;

  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Free-running H/V pixel counters with registered sync, display-enable and
// frame-start decode, each aligned to the counter value it describes.
module vga_sync_counter #(
  parameter int H_VISIBLE        = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT          = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC           = vga_timing_pkg::H_SYNC,
  parameter int H_BACK           = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE        = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT          = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC           = vga_timing_pkg::V_SYNC,
  parameter int V_BACK           = vga_timing_pkg::V_BACK,
  parameter int SYNC_ACTIVE_HIGH = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic [vga_timing_pkg::CNT_W-1:0] x_o,
  output logic [vga_timing_pkg::CNT_W-1:0] y_o,
  output logic                             hsync_o,
  output logic                             vsync_o,
  output logic                             de_o,
  output logic                             frame_start_o,
  output logic                             frame_tick_o
);
  import vga_timing_pkg::*;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_VISIBLE);
  localparam logic             SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             hsync_q, vsync_q, de_q, fs_q;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
    end
  end

  assign frame_tick_o = (x_q == H_LAST) && (y_q == V_LAST);

  // NOTE: flags decode the next-state counters so they register on the same edge as X/Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= in_window(x_d, HS_FIRST, HS_LAST) ? SYNC_ON : ~SYNC_ON;
      vsync_q <= in_window(y_d, VS_FIRST, VS_LAST) ? SYNC_ON : ~SYNC_ON;
      de_q    <= (x_d < H_ACT) && (y_d < V_ACT);
      fs_q    <= frame_tick_o;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_frame_controller.sv
// VGA timing controller: sync/position generation plus a frame-boundary
// pattern sequencer so a pattern change never tears a visible frame.
module vga_frame_controller #(
  parameter int H_VISIBLE          = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT            = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC             = vga_timing_pkg::H_SYNC,
  parameter int H_BACK             = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE          = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT            = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC             = vga_timing_pkg::V_SYNC,
  parameter int V_BACK             = vga_timing_pkg::V_BACK,
  parameter int SYNC_ACTIVE_HIGH   = 1,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic                        pixelClock,
  input  logic                        resetN,
  input  logic                        autoCycle,
  input  logic                        advanceRequest,
  output logic [10:0]                 XPixelPosition,
  output logic [10:0]                 YPixelPosition,
  output logic                        hSync,
  output logic                        vSync,
  output logic                        displayEnable,
  output logic                        frameStart,
  output vga_timing_pkg::pattern_idx_t patternIndex
);
  import vga_timing_pkg::*;

  localparam int             FC_W    = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_PATTERN - 1);

  logic frame_tick;
  logic auto_due;

  seq_state_t      state_q;
  pattern_idx_t    pattern_q;
  logic [FC_W-1:0] frame_cnt_q;

  vga_sync_counter #(
    .H_VISIBLE       (H_VISIBLE),
    .H_FRONT         (H_FRONT),
    .H_SYNC          (H_SYNC),
    .H_BACK          (H_BACK),
    .V_VISIBLE       (V_VISIBLE),
    .V_FRONT         (V_FRONT),
    .V_SYNC          (V_SYNC),
    .V_BACK          (V_BACK),
    .SYNC_ACTIVE_HIGH(SYNC_ACTIVE_HIGH)
  ) u_sync (
    .clk          (pixelClock),
    .rst_n        (resetN),
    .x_o          (XPixelPosition),
    .y_o          (YPixelPosition),
    .hsync_o      (hSync),
    .vsync_o      (vSync),
    .de_o         (displayEnable),
    .frame_start_o(frameStart),
    .frame_tick_o (frame_tick)
  );

  assign auto_due = autoCycle && (frame_cnt_q == FC_LAST);

  // frame_tick is the edge that loads X=0,Y=0, so pattern changes coincide with frameStart.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= SEQ_IDLE;
      pattern_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (frame_tick && (state_q == SEQ_PENDING || auto_due)) begin
        pattern_q <= pattern_q + 1'b1;
        state_q   <= advanceRequest ? SEQ_PENDING : SEQ_IDLE;
      end else if (advanceRequest) begin
        state_q <= SEQ_PENDING;
      end

      if (!autoCycle || (frame_tick && auto_due)) begin
        frame_cnt_q <= '0;
      end else if (frame_tick) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign patternIndex = pattern_q;

endmodule

// File: tb/tb_vga_frame_controller.sv
// Directed bench: full-size instance for line timing, a shrunken instance
// (16x10 frame, active-low syncs, 2 frames/pattern) for frame and sequencer cases.
module tb_vga_frame_controller;

  localparam int FULL_H     = 1688;
  localparam int FULL_FRAME = 1688 * 1066;
  localparam int SM_H       = 16;
  localparam int SM_FRAME   = 16 * 10;

  logic clk = 1'b0;
  logic rst_n;
  logic auto_cycle;
  logic adv_req;

  logic [10:0] f_x, f_y, s_x, s_y;
  logic        f_hs, f_vs, f_de, f_fs;
  logic        s_hs, s_vs, s_de, s_fs;
  logic [2:0]  f_pat, s_pat;

  int checks = 0;
  int errors = 0;
  int full_pos;
  int sm_pos;

  always #5 clk = ~clk;

  vga_frame_controller dut_full (
    .pixelClock    (clk),
    .resetN        (rst_n),
    .autoCycle     (auto_cycle),
    .advanceRequest(adv_req),
    .XPixelPosition(f_x),
    .YPixelPosition(f_y),
    .hSync         (f_hs),
    .vSync         (f_vs),
    .displayEnable (f_de),
    .frameStart    (f_fs),
    .patternIndex  (f_pat)
  );

  vga_frame_controller #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(0), .FRAMES_PER_PATTERN(2)
  ) dut_sm (
    .pixelClock    (clk),
    .resetN        (rst_n),
    .autoCycle     (auto_cycle),
    .advanceRequest(adv_req),
    .XPixelPosition(s_x),
    .YPixelPosition(s_y),
    .hSync         (s_hs),
    .vSync         (s_vs),
    .displayEnable (s_de),
    .frameStart    (s_fs),
    .patternIndex  (s_pat)
  );

  typedef struct {
    string name;
    int    x;
    int    y;
    logic  hs;
    logic  de;
    logic  fs;
  } line_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      full_pos = (full_pos + 1) % FULL_FRAME;
      sm_pos   = (sm_pos + 1) % SM_FRAME;
    end
  endtask

  task automatic goto_full(input int x, input int y);
    step(y * FULL_H + x - full_pos);
  endtask

  task automatic goto_sm(input int x, input int y);
    step((y * SM_H + x - sm_pos + SM_FRAME) % SM_FRAME);
  endtask

  task automatic pulse_adv();
    adv_req = 1'b1;
    step(1);
    adv_req = 1'b0;
  endtask

  initial begin
    line_vec_t  vecs[9];
    logic [2:0] exp_pat;
    int hs_cnt, hs_first, de_low;
    int gap, vs_cnt, vs_first, de_cnt, de_bad;

    vecs[0] = '{"de_last",  1279, 0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"de_off",   1280, 0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"pre_hs",   1327, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"hs_first", 1328, 0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"hs_last",  1439, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"hs_end",   1440, 0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"line_end", 1687, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"x_wrap",   0,    1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{"line1",    5,    1, 1'b0, 1'b1, 1'b0};

    rst_n      = 1'b0;
    auto_cycle = 1'b0;
    adv_req    = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_full_x", f_x, 1687);
    check("rst_full_y", f_y, 1065);
    check("rst_full_hs", f_hs, 0);
    check("rst_full_vs", f_vs, 0);
    check("rst_full_de", f_de, 0);
    check("rst_full_fs", f_fs, 0);
    check("rst_full_pat", f_pat, 0);
    check("rst_sm_x", s_x, 15);
    check("rst_sm_y", s_y, 9);
    check("rst_sm_hs", s_hs, 1);
    check("rst_sm_vs", s_vs, 1);

    rst_n    = 1'b1;
    full_pos = FULL_FRAME - 1;
    sm_pos   = SM_FRAME - 1;

    step(1);
    check("first_x", f_x, 0);
    check("first_y", f_y, 0);
    check("first_fs", f_fs, 1);
    check("first_de", f_de, 1);
    check("first_pat", f_pat, 0);
    check("first_sm_fs", s_fs, 1);
    check("first_sm_hs", s_hs, 1);
    step(1);
    check("second_x", f_x, 1);
    check("second_fs", f_fs, 0);

    for (int i = 0; i < 9; i++) begin
      goto_full(vecs[i].x, vecs[i].y);
      check({vecs[i].name, "_x"},  f_x,  vecs[i].x);
      check({vecs[i].name, "_y"},  f_y,  vecs[i].y);
      check({vecs[i].name, "_hs"}, f_hs, vecs[i].hs);
      check({vecs[i].name, "_vs"}, f_vs, 0);
      check({vecs[i].name, "_de"}, f_de, vecs[i].de);
      check({vecs[i].name, "_fs"}, f_fs, vecs[i].fs);
    end

    hs_cnt = 0; hs_first = -1; de_low = 0;
    for (int i = 0; i < FULL_H; i++) begin
      step(1);
      if (f_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = full_pos % FULL_H;
      end
      if (f_de !== 1'b1) de_low++;
    end
    check("hs_width", hs_cnt, 112);
    check("hs_start_x", hs_first, 1328);
    check("de_low_per_line", de_low, 408);

    goto_sm(15, 9);
    step(1);
    check("sm_fs", s_fs, 1);
    gap = -1; vs_cnt = 0; vs_first = -1; de_cnt = 0; de_bad = 0;
    for (int i = 1; i <= SM_FRAME; i++) begin
      step(1);
      if (s_fs === 1'b1 && gap < 0) gap = i;
      if (s_vs === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = sm_pos;
      end
      if (s_de === 1'b1) begin
        de_cnt++;
        if (sm_pos / SM_H >= 6) de_bad++;
      end
    end
    check("frame_period", gap, SM_FRAME);
    check("vs_cycles", vs_cnt, 32);
    check("vs_first_pos", vs_first, 7 * SM_H);
    check("de_cycles", de_cnt, 48);
    check("de_in_vblank", de_bad, 0);

    goto_sm(0, 5);
    pulse_adv();
    check("man_hold", s_pat, 0);
    goto_sm(15, 9);
    check("man_pre_edge", s_pat, 0);
    step(1);
    check("man_step_fs", s_fs, 1);
    check("man_step", s_pat, 1);

    goto_sm(0, 2);
    pulse_adv();
    goto_sm(3, 4);
    pulse_adv();
    goto_sm(15, 9);
    step(1);
    check("dbl_step", s_pat, 2);
    goto_sm(15, 9);
    step(1);
    check("dbl_once", s_pat, 2);

    pulse_adv();
    check("fs_req_defer", s_pat, 2);
    goto_sm(15, 9);
    check("fs_req_hold", s_pat, 2);
    step(1);
    check("fs_req_apply", s_pat, 3);

    exp_pat = 3'd3;
    goto_sm(0, 3);
    auto_cycle = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      goto_sm(15, 9);
      step(1);
      if (k % 2 == 0) exp_pat = exp_pat + 3'd1;
      check($sformatf("auto_f%0d", k), s_pat, exp_pat);
    end
    check("auto_wrap16", s_pat, 3);

    for (int k = 17; k <= 20; k++) begin
      if (k == 18) begin
        goto_sm(0, 4);
        pulse_adv();
      end
      goto_sm(15, 9);
      step(1);
      if (k % 2 == 0) exp_pat = exp_pat + 3'd1;
      check($sformatf("auto_man_f%0d", k), s_pat, exp_pat);
    end
    auto_cycle = 1'b0;

    goto_sm(5, 3);
    pulse_adv();
    goto_sm(8, 4);
    #4;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sm_x", s_x, 15);
    check("mid_rst_sm_y", s_y, 9);
    check("mid_rst_sm_hs", s_hs, 1);
    check("mid_rst_sm_vs", s_vs, 1);
    check("mid_rst_sm_de", s_de, 0);
    check("mid_rst_sm_fs", s_fs, 0);
    check("mid_rst_sm_pat", s_pat, 0);
    check("mid_rst_full_x", f_x, 1687);
    check("mid_rst_full_y", f_y, 1065);
    check("mid_rst_full_hs", f_hs, 0);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    full_pos = FULL_FRAME - 1;
    sm_pos   = SM_FRAME - 1;
    step(1);
    check("post_rst_x", s_x, 0);
    check("post_rst_fs", s_fs, 1);
    check("post_rst_pat", s_pat, 0);
    goto_sm(15, 9);
    step(1);
    check("pending_lost", s_pat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
